// File: rtl/vend_session_controller_if.sv
// Coin/keypad and dispenser signal bundle for vend_session_controller.
// Restock/sold-out signals exist only when VEND_STOCK_TRACK_EN is defined.
interface vend_session_controller_if;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       select_valid;
    logic [1:0] product_select;
    logic       buy_more;
    logic       cancel;
    logic       disp_ack;
    logic       disp_req;
    logic [1:0] disp_product;
    logic [7:0] credit;
    logic [7:0] change;
    logic       change_valid;
    logic       insufficient;
    logic       coin_reject;
    logic       disp_fault;
    logic       busy;
`ifdef VEND_STOCK_TRACK_EN
    logic       restock;
    logic [1:0] restock_product;
    logic       sold_out;
`endif

    // Environment side: coin acceptor, keypad and dispenser mechanism
    modport master (
`ifdef VEND_STOCK_TRACK_EN
        output restock, output restock_product, input sold_out,
`endif
        output coin_valid, output coin_value, output select_valid,
        output product_select, output buy_more, output cancel, output disp_ack,
        input disp_req, input disp_product, input credit, input change,
        input change_valid, input insufficient, input coin_reject,
        input disp_fault, input busy
    );

    // Controller side
    modport slave (
`ifdef VEND_STOCK_TRACK_EN
        input restock, input restock_product, output sold_out,
`endif
        input coin_valid, input coin_value, input select_valid,
        input product_select, input buy_more, input cancel, input disp_ack,
        output disp_req, output disp_product, output credit, output change,
        output change_valid, output insufficient, output coin_reject,
        output disp_fault, output busy
    );
endinterface

// File: rtl/vend_session_controller.sv
// Vending session sequencer: coin credit, price check, dispenser req/ack, change.
// Optional per-product stock tracking is enabled by defining VEND_STOCK_TRACK_EN.
module vend_session_controller #(
    parameter int unsigned PRICE0       = 25,
    parameter int unsigned PRICE1       = 50,
    parameter int unsigned PRICE2       = 75,
    parameter int unsigned PRICE3       = 100,
    parameter int unsigned CREDIT_MAX   = 255,
    parameter int unsigned IDLE_TIMEOUT = 1000,
    parameter int unsigned ACK_TIMEOUT  = 16
) (
    input logic                      clk,
    input logic                      reset,
    vend_session_controller_if.slave bus
);
    localparam int unsigned TMR_MAX = (IDLE_TIMEOUT > ACK_TIMEOUT) ? IDLE_TIMEOUT : ACK_TIMEOUT;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CREDIT   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [7:0]    credit_q, credit_n;
    logic [1:0]    prod_q, prod_n;
    logic [TW-1:0] tmr_q, tmr_n;
    logic [7:0]    change_q, change_n;
    logic          change_valid_q, change_valid_n;
    logic          insufficient_q, insufficient_n;
    logic          coin_reject_q, coin_reject_n;
    logic          disp_fault_q, disp_fault_n;
    logic          disp_req_q, disp_req_n;
    logic          busy_q, busy_n;
    logic [8:0]    sum;
    logic [7:0]    price;
    logic          coin_ok;
`ifdef VEND_STOCK_TRACK_EN
    logic [3:0][3:0] stock_q, stock_n;
    logic            sold_out_q, sold_out_n;
`endif

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'(PRICE0);
            2'd1:    return 8'(PRICE1);
            2'd2:    return 8'(PRICE2);
            default: return 8'(PRICE3);
        endcase
    endfunction

    // Next-state, credit datapath and output pulses
    always_comb begin
        state_n        = state;
        credit_n       = credit_q;
        prod_n         = prod_q;
        tmr_n          = tmr_q;
        change_n       = change_q;
        change_valid_n = 1'b0;
        insufficient_n = 1'b0;
        coin_reject_n  = 1'b0;
        disp_fault_n   = 1'b0;
        sum            = 9'(credit_q) + 9'(bus.coin_value);
        price          = price_of(prod_q);
        coin_ok        = 1'b0;
`ifdef VEND_STOCK_TRACK_EN
        stock_n        = stock_q;
        sold_out_n     = 1'b0;
`endif

        unique case (state)
            ST_IDLE: begin
                // Credit is always zero here, so any selection is short
                if (bus.select_valid) insufficient_n = 1'b1;
                if (bus.coin_valid) begin
                    credit_n = bus.coin_value;
                    tmr_n    = '0;
                    state_n  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                tmr_n = tmr_q + TW'(1);
                if (bus.cancel) begin
                    coin_reject_n = bus.coin_valid;
                    state_n       = ST_CHANGE;
                end else begin
                    if (bus.coin_valid) begin
                        if (sum > 9'(CREDIT_MAX)) begin
                            coin_reject_n = 1'b1;
                        end else begin
                            credit_n = sum[7:0];
                            coin_ok  = 1'b1;
                            tmr_n    = '0;
                        end
                    end
                    if (bus.select_valid) begin
                        prod_n  = bus.product_select;
                        tmr_n   = '0;
                        state_n = ST_CHECK;
                    end else if (!coin_ok && tmr_q == TW'(IDLE_TIMEOUT - 1)) begin
                        state_n = ST_CHANGE;
                    end
                end
            end
            ST_CHECK: begin
                coin_reject_n = bus.coin_valid;
                tmr_n         = '0;
`ifdef VEND_STOCK_TRACK_EN
                if (stock_q[prod_q] == 4'd0) begin
                    sold_out_n = 1'b1;
                    state_n    = ST_CREDIT;
                end else
`endif
                if (credit_q >= price) begin
                    credit_n = credit_q - price;
                    state_n  = ST_DISPENSE;
                end else begin
                    insufficient_n = 1'b1;
                    state_n        = ST_CREDIT;
                end
            end
            ST_DISPENSE: begin
                coin_reject_n = bus.coin_valid;
                tmr_n         = tmr_q + TW'(1);
                if (bus.disp_ack) begin
                    tmr_n   = '0;
                    state_n = (bus.buy_more && credit_q != 8'd0) ? ST_CREDIT : ST_CHANGE;
`ifdef VEND_STOCK_TRACK_EN
                    if (stock_q[prod_q] != 4'd0) stock_n[prod_q] = stock_q[prod_q] - 4'd1;
`endif
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    // Nothing was vended: give the price back before refunding
                    credit_n     = credit_q + price;
                    disp_fault_n = 1'b1;
                    state_n      = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                coin_reject_n = bus.coin_valid;
                tmr_n         = '0;
                if (credit_q != 8'd0) begin
                    change_n       = credit_q;
                    change_valid_n = 1'b1;
                end
                credit_n = '0;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

`ifdef VEND_STOCK_TRACK_EN
        if (bus.restock) stock_n[bus.restock_product] = 4'hF;
`endif
        disp_req_n = (state_n == ST_DISPENSE);
        busy_n     = (state_n != ST_IDLE) && (state_n != ST_CREDIT);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            credit_q       <= '0;
            prod_q         <= '0;
            tmr_q          <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            insufficient_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            disp_fault_q   <= 1'b0;
            disp_req_q     <= 1'b0;
            busy_q         <= 1'b0;
`ifdef VEND_STOCK_TRACK_EN
            stock_q        <= '0;
            sold_out_q     <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            credit_q       <= credit_n;
            prod_q         <= prod_n;
            tmr_q          <= tmr_n;
            change_q       <= change_n;
            change_valid_q <= change_valid_n;
            insufficient_q <= insufficient_n;
            coin_reject_q  <= coin_reject_n;
            disp_fault_q   <= disp_fault_n;
            disp_req_q     <= disp_req_n;
            busy_q         <= busy_n;
`ifdef VEND_STOCK_TRACK_EN
            stock_q        <= stock_n;
            sold_out_q     <= sold_out_n;
`endif
        end
    end

    assign bus.disp_req     = disp_req_q;
    assign bus.disp_product = prod_q;
    assign bus.credit       = credit_q;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;
    assign bus.insufficient = insufficient_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.disp_fault   = disp_fault_q;
    assign bus.busy         = busy_q;
`ifdef VEND_STOCK_TRACK_EN
    assign bus.sold_out     = sold_out_q;
`endif

endmodule
